// File: rtl/leaf_out_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ack output port between NUM_REQ
// producer streams, granting bursts of up to MAX_BURST words per requester.
module leaf_out_rr_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned PAYLOAD_BITS = 32,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned REQ_ID_BITS  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req,
    input  logic [NUM_REQ-1:0]              vld_req,
    output logic [NUM_REQ-1:0]              ack_req,
    output logic [PAYLOAD_BITS-1:0]         dout,
    output logic                            vld_out,
    input  logic                            ack_out,
    output logic [REQ_ID_BITS-1:0]          dout_src,
    output logic                            grant_valid,
    output logic [REQ_ID_BITS-1:0]          grant_id
);

    localparam int unsigned CntW = $clog2(MAX_BURST) + 1;

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e                    state_q, state_d;
    logic [REQ_ID_BITS-1:0]    grant_q, grant_d;
    logic [REQ_ID_BITS-1:0]    ptr_q, ptr_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      out_vld_q, out_vld_d;
    logic [PAYLOAD_BITS-1:0]   dout_q, dout_d;
    logic [REQ_ID_BITS-1:0]    dout_src_q, dout_src_d;

    logic                      can_load;
    logic                      cur_vld;
    logic [PAYLOAD_BITS-1:0]   cur_data;
    logic                      found;
    logic [REQ_ID_BITS-1:0]    pick_id;
    int unsigned               idx;
    logic                      xfer;
    logic [REQ_ID_BITS-1:0]    next_ptr;

    assign can_load = !out_vld_q || ack_out;
    assign next_ptr = (grant_q == REQ_ID_BITS'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    // Mux the granted requester's valid and data.
    always_comb begin
        cur_vld  = 1'b0;
        cur_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == REQ_ID_BITS'(i)) begin
                cur_vld  = vld_req[i];
                cur_data = din_req[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        found   = 1'b0;
        pick_id = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr_q) + k) % NUM_REQ;
            if (!found && vld_req[idx]) begin
                found   = 1'b1;
                pick_id = REQ_ID_BITS'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ack_req = '0;
        xfer    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable && found) begin
                    grant_d = pick_id;
                    cnt_d   = '0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                xfer = cur_vld && can_load;
                if (xfer) begin
                    ack_req = NUM_REQ'(1) << grant_q;
                    cnt_d   = cnt_q + 1'b1;
                end
                if ((xfer && cnt_q == CntW'(MAX_BURST - 1)) || !cur_vld) begin
                    state_d = StIdle;
                    ptr_d   = next_ptr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Load and drain in the same cycle is a pass-through; out_vld stays set.
    always_comb begin
        out_vld_d  = out_vld_q;
        dout_d     = dout_q;
        dout_src_d = dout_src_q;
        if (xfer) begin
            out_vld_d  = 1'b1;
            dout_d     = cur_data;
            dout_src_d = grant_q;
        end else if (ack_out) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            out_vld_q  <= 1'b0;
            dout_q     <= '0;
            dout_src_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            out_vld_q  <= out_vld_d;
            dout_q     <= dout_d;
            dout_src_q <= dout_src_d;
        end
    end

    assign dout        = dout_q;
    assign vld_out     = out_vld_q;
    assign dout_src    = dout_src_q;
    assign grant_valid = (state_q == StBurst);
    assign grant_id    = grant_q;

endmodule

// File: doc/leaf_out_rr_arbiter.md
Name: leaf_out_rr_arbiter

Overview:
- Round-robin arbiter that shares one leaf_interface output port (din/vld/ack, 32-bit payload) between NUM_REQ user-side producer streams.
- Sits between several HLS kernel output streams and a single vld_user2interface/ack_interface2user channel.
- Grants one requester at a time for a burst of up to MAX_BURST words, then rotates.
- Output data is registered; the arbiter never reorders or drops words.

Parameters:
- NUM_REQ, 4, number of requester streams (2..16).
- PAYLOAD_BITS, 32, data width per word.
- MAX_BURST, 16, maximum words per grant (>=1; 1 gives word-level round robin).
- REQ_ID_BITS, 4, width of grant_id and dout_src (must satisfy 2^REQ_ID_BITS >= NUM_REQ).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when low, no new grant is issued; a burst already in progress completes.
- din_req  in  NUM_REQ*PAYLOAD_BITS  requester data; requester i occupies slice i.
- vld_req  in  NUM_REQ  per-requester valid.
- ack_req  out  NUM_REQ  per-requester accept; one-hot or zero.
- dout  out  PAYLOAD_BITS  registered output word toward leaf_interface.
- vld_out  out  1  output valid.
- ack_out  in  1  downstream accept.
- dout_src  out  REQ_ID_BITS  index of the requester that produced the current dout.
- grant_valid  out  1  high while in BURST.
- grant_id  out  REQ_ID_BITS  currently granted requester.

Behaviour:
- Handshake: a word transfers on a rising edge where vld and ack are both high on the same interface.
  - Producers must hold vld and data stable until ack.
  - ack_req is combinational from registered state, vld_req and ack_out.
- Output register (out_vld, dout, dout_src):
  - can_load = !out_vld || ack_out.
  - On an upstream transfer: load din_req[grant] and grant_id, set out_vld=1.
  - Else if ack_out: clear out_vld.
- FSM with states IDLE and BURST.
  - IDLE:
    - ack_req=0.
    - If enable and any vld_req: pick the first i with vld_req[i] high, scanning ptr, ptr+1, ... mod NUM_REQ.
    - Then grant_id<=i, cnt<=0, go to BURST. Selection takes one cycle.
  - BURST:
    - ack_req[grant_id] = vld_req[grant_id] && can_load.
    - On transfer: cnt<=cnt+1.
    - Exit to IDLE when (transfer && cnt==MAX_BURST-1) or (vld_req[grant_id]==0).
    - On exit: ptr <= (grant_id+1) mod NUM_REQ.
    - Stall (vld high, can_load low) holds BURST and cnt.
- Latency:
  - Requester vld_req rises at cycle t with the FSM idle: grant at t+1, ack_req at t+1 if can_load, word on dout at t+2.
  - Sustained throughput within a burst is 1 word/cycle when ack_out stays high.
  - There is one IDLE bubble cycle between bursts.
- Fairness: a requester that keeps vld high is pre-empted after MAX_BURST words. Every other requesting stream is served within NUM_REQ-1 bursts.
- enable low:
  - Ignored in BURST.
  - In IDLE, holds IDLE; ptr is unchanged.
- cnt width: clog2(MAX_BURST)+1 bits; it never wraps because it resets on exit.
- Reset (any time, including mid-burst):
  - state=IDLE, ptr=0, cnt=0, grant_id=0.
  - out_vld=0, dout=0, dout_src=0.
  - ack_req=0, grant_valid=0.
  - A word held in the output register is discarded.
- Simultaneous events:
  - Output register drain (ack_out) and load in the same cycle is a legal pass-through; out_vld stays 1.
  - A requester dropping vld exactly as its burst count expires exits once; ptr still advances past it.

Test Plan:
- Single requester 2 streams 5 words, ack_out=1, MAX_BURST=16 -> grant_id=2 one cycle after vld, dout shows the 5 words in order on consecutive cycles with dout_src=2, then FSM returns to IDLE and ptr=3.
- All 4 requesters continuously valid, MAX_BURST=4 -> 4-word bursts in order 0,1,2,3,0, with one bubble cycle between bursts; no requester exceeds 4 consecutive words.
- Backpressure: ack_out pattern 1,0,0,1,1 during a burst -> ack_req held low while out_vld=1 and ack_out=0; no word duplicated or lost; cnt frozen during the stall.
- MAX_BURST=1, requesters 0 and 3 valid -> output alternates sources 0,3,0,3.
- enable=0 mid-burst on requester 1 (word 2 of 8) -> burst completes all 8 words, then no new grant while enable=0; grant resumes at requester 2 when enable=1.
- Reset asserted asynchronously mid-burst with out_vld=1 -> vld_out, ack_req and grant_valid fall immediately; after release, arbitration restarts from ptr=0.
